// File: rtl/capture_ctrl_if.sv
// Bundles the capture sequencer's control, trigger-handshake and sample-RAM write signals.
// Timeout signals exist only when CAPTURE_TIMEOUT_EN is defined.
interface capture_ctrl_if #(
   parameter int unsigned dsize = 32,
   parameter int unsigned aw    = 12
);
   logic             start;
   logic             stop;
   logic             sample_en;
   logic [dsize-1:0] dinput;
   logic [aw-1:0]    pretrig_count;
   logic [aw-1:0]    posttrig_count;
   logic             trig_triggered;
   logic             trig_armed;
   logic             trig_arm;
   logic             trig_abort;
   logic             trig_ignore;
   logic             mem_we;
   logic [aw-1:0]    mem_addr;
   logic [dsize-1:0] mem_data;
   logic [aw-1:0]    trig_addr;
   logic [aw-1:0]    end_addr;
   logic             busy;
   logic             done;
`ifdef CAPTURE_TIMEOUT_EN
   logic [31:0]      timeout_limit;
   logic             timed_out;
`endif

   modport slave (
      input  start, stop, sample_en, dinput, pretrig_count, posttrig_count,
             trig_triggered, trig_armed,
      output trig_arm, trig_abort, trig_ignore, mem_we, mem_addr, mem_data,
             trig_addr, end_addr, busy, done
`ifdef CAPTURE_TIMEOUT_EN
      , input timeout_limit, output timed_out
`endif
   );

   modport master (
      output start, stop, sample_en, dinput, pretrig_count, posttrig_count,
             trig_triggered, trig_armed,
      input  trig_arm, trig_abort, trig_ignore, mem_we, mem_addr, mem_data,
             trig_addr, end_addr, busy, done
`ifdef CAPTURE_TIMEOUT_EN
      , output timeout_limit, input timed_out
`endif
   );
endinterface

// File: rtl/capture_ctrl.sv
// Logic-analyser acquisition sequencer: pre-trigger fill, arm, wait, post-trigger fill.
// Define CAPTURE_TIMEOUT_EN to add a sample-counted timeout while waiting for the trigger.
module capture_ctrl #(
   parameter int unsigned dsize = 32,
   parameter int unsigned aw    = 12
) (
   input logic           clk,
   input logic           reset,
   capture_ctrl_if.slave ctrl_io
);
   typedef enum logic [2:0] {
      StIdle, StPre, StArming, StWait, StPost, StDone, StAbort
   } state_e;

   state_e           state_q, state_d;
   logic [aw-1:0]    wr_ptr_q, wr_ptr_d, wr_ptr_nxt;
   logic [aw-1:0]    cnt_q, cnt_d, cnt_nxt;
   logic [aw-1:0]    trig_addr_q, trig_addr_d;
   logic [aw-1:0]    end_addr_q, end_addr_d;
   logic [aw-1:0]    mem_addr_q;
   logic [dsize-1:0] mem_data_q;
   logic             mem_we_q, trig_arm_q, trig_arm_d;
   logic             writing, wr_fire;

   assign writing    = state_q inside {StPre, StArming, StWait, StPost};
   assign wr_fire    = writing & ctrl_io.sample_en;
   assign wr_ptr_nxt = wr_fire ? wr_ptr_q + aw'(1) : wr_ptr_q;
   assign cnt_nxt    = cnt_q + aw'(1);

`ifdef CAPTURE_TIMEOUT_EN
   logic [31:0] to_cnt_q, to_cnt_d;
   logic        timed_out_q, timed_out_d, to_hit;

   assign to_hit = (ctrl_io.timeout_limit != 32'd0) && ctrl_io.sample_en &&
                   ((to_cnt_q + 32'd1) == ctrl_io.timeout_limit);
   assign ctrl_io.timed_out = timed_out_q;
`endif

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_nxt;
      cnt_d       = cnt_q;
      trig_addr_d = trig_addr_q;
      end_addr_d  = end_addr_q;
      trig_arm_d  = 1'b0;
`ifdef CAPTURE_TIMEOUT_EN
      to_cnt_d    = to_cnt_q;
      timed_out_d = timed_out_q;
`endif
      unique case (state_q)
         StIdle, StDone: begin
            if (state_q == StDone && ctrl_io.stop) begin
               state_d = StIdle;
            end else if (ctrl_io.start) begin
               wr_ptr_d = '0;
               cnt_d    = '0;
`ifdef CAPTURE_TIMEOUT_EN
               timed_out_d = 1'b0;
`endif
               if (ctrl_io.pretrig_count == '0) begin
                  state_d    = StArming;
                  trig_arm_d = 1'b1;
               end else begin
                  state_d = StPre;
               end
            end
         end
         StPre: begin
            if (ctrl_io.stop) begin
               state_d = StIdle;
            end else if (ctrl_io.sample_en) begin
               cnt_d = cnt_nxt;
               if (cnt_nxt == ctrl_io.pretrig_count) begin
                  trig_arm_d = 1'b1;
                  cnt_d      = '0;
                  state_d    = StArming;
               end
            end
         end
         // A triggered flag left over from the last run is ignored until armed is seen.
         StArming: begin
            if (ctrl_io.stop) begin
               state_d = StAbort;
            end else if (ctrl_io.trig_armed) begin
               state_d = StWait;
`ifdef CAPTURE_TIMEOUT_EN
               to_cnt_d = '0;
`endif
            end
         end
         StWait: begin
`ifdef CAPTURE_TIMEOUT_EN
            if (ctrl_io.sample_en) to_cnt_d = to_cnt_q + 32'd1;
`endif
            if (ctrl_io.stop) begin
               state_d = StAbort;
            end else if (ctrl_io.trig_triggered) begin
               trig_addr_d = wr_ptr_nxt;
               if (ctrl_io.posttrig_count == '0) begin
                  end_addr_d = wr_ptr_nxt;
                  state_d    = StDone;
               end else begin
                  state_d = StPost;
               end
            end
`ifdef CAPTURE_TIMEOUT_EN
            else if (to_hit) begin
               state_d     = StAbort;
               timed_out_d = 1'b1;
            end
`endif
         end
         StPost: begin
            if (ctrl_io.stop) begin
               state_d = StIdle;
            end else if (ctrl_io.sample_en) begin
               cnt_d = cnt_nxt;
               if (cnt_nxt == ctrl_io.posttrig_count) begin
                  end_addr_d = wr_ptr_nxt;
                  state_d    = StDone;
               end
            end
         end
         StAbort: begin
            if (!ctrl_io.trig_armed) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         wr_ptr_q    <= '0;
         cnt_q       <= '0;
         trig_addr_q <= '0;
         end_addr_q  <= '0;
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
         mem_we_q    <= 1'b0;
         trig_arm_q  <= 1'b0;
`ifdef CAPTURE_TIMEOUT_EN
         to_cnt_q    <= '0;
         timed_out_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         cnt_q       <= cnt_d;
         trig_addr_q <= trig_addr_d;
         end_addr_q  <= end_addr_d;
         mem_we_q    <= wr_fire;
         trig_arm_q  <= trig_arm_d;
         if (wr_fire) begin
            mem_addr_q <= wr_ptr_q;
            mem_data_q <= ctrl_io.dinput;
         end
`ifdef CAPTURE_TIMEOUT_EN
         to_cnt_q    <= to_cnt_d;
         timed_out_q <= timed_out_d;
`endif
      end
   end

   assign ctrl_io.trig_arm    = trig_arm_q;
   assign ctrl_io.trig_abort  = (state_q == StAbort);
   // The trigger only evaluates on sample cycles; it must see abort unmasked.
   assign ctrl_io.trig_ignore = (state_q inside {StArming, StWait}) ? ~ctrl_io.sample_en
                                                                   : (state_q != StAbort);
   assign ctrl_io.mem_we      = mem_we_q;
   assign ctrl_io.mem_addr    = mem_addr_q;
   assign ctrl_io.mem_data    = mem_data_q;
   assign ctrl_io.trig_addr   = trig_addr_q;
   assign ctrl_io.end_addr    = end_addr_q;
   assign ctrl_io.busy        = state_q inside {StPre, StArming, StWait, StPost, StAbort};
   assign ctrl_io.done        = (state_q == StDone);
endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
- Sequencer that runs one logic-analyser acquisition around the 8-level trigger block.
- Writes pre-trigger samples into a circular sample RAM, then arms the trigger and keeps writing while the trigger waits.
- After the trigger fires, writes a fixed number of post-trigger samples, then reports done plus trigger and end addresses.
- Drives the trigger's arm, abort and ignore inputs, and the write port of the sample RAM.

Parameters:
dsize, 32, sample width (matches trigger dsize)
aw, 12, sample RAM address width; depth = 2^aw

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  begin acquisition (level; sampled in IDLE/DONE)
stop  in  1  cancel acquisition (level)
sample_en  in  1  sample strobe from rate divider
dinput  in  dsize  live probe inputs
pretrig_count  in  aw  samples to write before arming
posttrig_count  in  aw  samples to write after trigger
trig_triggered  in  1  trigger "triggered" output
trig_armed  in  1  trigger "armed" output
trig_arm  out  1  trigger arm strobe
trig_abort  out  1  trigger abort
trig_ignore  out  1  trigger ignore (freeze)
mem_we  out  1  RAM write enable
mem_addr  out  aw  RAM write address
mem_data  out  dsize  RAM write data
trig_addr  out  aw  address of first sample after trigger
end_addr  out  aw  address one past last written sample
busy  out  1  acquisition in progress
done  out  1  acquisition complete

Behaviour:
- Reset: state IDLE, wr_ptr=0, cnt=0. All outputs 0 except trig_ignore=1.
- States: IDLE, PRE, ARMING, WAIT, POST, DONE, ABORT. busy=1 in PRE/ARMING/WAIT/POST/ABORT. done=1 only in DONE.
- IDLE/DONE, start=1:
  - wr_ptr<=0, cnt<=0, trig_addr/end_addr hold.
  - Next state PRE; if pretrig_count==0, go directly to ARMING and pulse trig_arm.
  - start is ignored in all other states.
- Sample write, in PRE/ARMING/WAIT/POST only:
  - On each sample_en cycle: mem_we<=1, mem_addr<=wr_ptr, mem_data<=dinput, wr_ptr<=wr_ptr+1.
  - Registered outputs, 1-cycle latency. mem_we=0 in all other cycles.
  - wr_ptr wraps 2^aw-1 -> 0; oldest data is overwritten with no flag.
- PRE:
  - cnt increments per sample_en.
  - When a sample_en makes cnt==pretrig_count: trig_arm=1 for exactly one cycle, cnt<=0, go to ARMING.
- ARMING:
  - Wait for trig_armed==1 (masks a stale trig_triggered from the previous run), then go to WAIT.
- trig_ignore:
  - In ARMING/WAIT: trig_ignore = ~sample_en (combinational), so the trigger evaluates only on sample cycles.
  - In ABORT: 0.
  - Elsewhere: 1.
- WAIT:
  - On trig_triggered==1: trig_addr<=wr_ptr (the next address, including a same-cycle increment).
  - If posttrig_count==0: end_addr<=that value, go to DONE.
  - Otherwise go to POST.
- POST:
  - cnt increments per sample_en.
  - When cnt reaches posttrig_count: end_addr<=wr_ptr after that write, go to DONE.
- stop=1:
  - In PRE/POST: go to IDLE next cycle.
  - In ARMING/WAIT: go to ABORT.
  - In DONE: go to IDLE, done clears.
  - In IDLE: no effect.
  - stop has priority over trigger and count completion in the same cycle.
- ABORT:
  - trig_abort=1, trig_ignore=0, held until trig_armed==0, then IDLE.
  - If the trigger fires during ABORT: still go to IDLE; trig_addr is not updated.
- reset mid-acquisition returns to the reset state; the trigger block is reset by the same reset.

Optional Feature:
- Macro: CAPTURE_TIMEOUT_EN.
- When defined, adds:
  - input timeout_limit[31:0]
  - output timed_out
  - a 32-bit counter cleared on entry to WAIT, incremented every sample_en in WAIT.
- When count==timeout_limit (limit !=0): go to ABORT and set timed_out=1. timed_out clears on start or reset.
- limit==0 disables the timeout.
- When not defined: no extra ports or logic; WAIT lasts until trigger or stop.

Test Plan:
- Normal run:
  - Stimulus: pretrig=4, post=3, sample_en every cycle, trigger fires on the 6th sample after arm.
  - Response: exactly one trig_arm pulse after 4 writes; trig_addr=10; end_addr=13; done=1; 13 writes at addresses 0..12.
- Zero counts:
  - Stimulus: pretrig=0, post=0.
  - Response: trig_arm in the cycle after start; DONE directly after trig_triggered; end_addr==trig_addr.
- Wrap:
  - Stimulus: aw=3, pretrig=6, trigger after 5 samples, post=4.
  - Response: mem_addr sequence wraps 7->0; trig_addr=3; end_addr=7.
- Stale trigger:
  - Stimulus: back-to-back runs with trig_triggered still 1 when the second run's trig_arm pulses.
  - Response: ARMING holds until trig_armed=1; no false done.
- Abort:
  - Stimulus: stop during WAIT.
  - Response: trig_abort=1 with trig_ignore=0 until trig_armed=0, then IDLE; done stays 0; mem_we=0 afterwards.
- Sparse sampling:
  - Stimulus: sample_en 1-in-4, pretrig=2.
  - Response: trig_ignore=1 on non-sample cycles; writes only on sample_en; timeout (if enabled, limit=5) asserts timed_out after 5 sample_en in WAIT.
